wb_arbiter2: RTL
================

# wb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the on-chip BRAM slave between the CPU data port (master 0) and the instruction-fetch port (master 1). It sits between the MiniMIPS32 bus interfaces and the BRAM Wishbone wrapper. Ownership is locked for a whole bus cycle (while the owner's cyc is high), ties are resolved round-robin, and a watchdog terminates transfers the slave never acknowledges.

## Interface
- TIMEOUT, 255: cycles of strobe without ack before an error termination (range 2..65535).
- wb_clk_i  in  1  system clock; all state changes on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- m0_cyc_i / m1_cyc_i  in  1  master cycle-valid (request and ownership lock).
- m0_stb_i / m1_stb_i  in  1  master strobe.
- m0_we_i / m1_we_i  in  1  master write enable.
- m0_sel_i / m1_sel_i  in  4  master byte selects.
- m0_adr_i / m1_adr_i  in  32  master address.
- m0_dat_i / m1_dat_i  in  32  master write data.
- m0_dat_o / m1_dat_o  out  32  read data; s_dat_i when owner, else 0.
- m0_ack_o / m1_ack_o  out  1  s_ack_i gated to the owner.
- m0_err_o / m1_err_o  out  1  one-cycle watchdog error pulse to the owner.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave-side control, from the owner.
- s_sel_o  out  4; s_adr_o, s_dat_o  out  32  slave-side selects, address, write data.
- s_dat_i  in  32; s_ack_i  in  1  slave read data and acknowledge (ack may be same-cycle combinational).
- gnt_o  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle.

## Operation
- FSM states: IDLE, GNT0, GNT1. Register last_gnt (1 bit) records the most recently granted master.
- IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant the master that is not last_gnt; neither -> stay.
- GNTx: stay while mx_cyc_i = 1 (stb toggling does not release). When mx_cyc_i = 0: other master's cyc = 1 -> GNT(other) directly; else IDLE.
- Entering GNTx sets last_gnt = x.
- Slave outputs are a combinational mux of the owner's inputs, selected by the registered state. IDLE drives s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o all 0.
- Non-owner ack_o, err_o, dat_o are 0. The owner's ack_o equals s_ack_i, and its dat_o equals s_dat_i.
- Watchdog: 16-bit counter, cleared outside GNTx, on s_ack_i, or on s_stb_o = 0. Otherwise it increments. When count = TIMEOUT-1 and s_ack_i = 0: pulse owner err_o for that cycle and clear the counter. s_stb_o is forced 0 during the err cycle. The state is not changed, because release is still governed by cyc.
- err_o and ack_o are never high in the same cycle.

## Timing
- Reset (synchronous): state IDLE, last_gnt = 1 (m0 wins the first tie), counter 0. All outputs 0 in the cycle after the reset edge.
- Reset mid-transfer: the next edge forces IDLE regardless of cyc or ack, with no ack or err to either master.
- Grant latency: cyc raised in cycle N while IDLE -> owner in N+1. With a same-cycle acking slave, first ack appears in N+1.
- Handover: owner drops cyc in cycle M while the other master requests -> the other master owns in M+1 (no idle bubble).
- A master raising cyc while the other owns waits. It is granted in the cycle after the owner releases.
- Back-to-back cycles from one master with cyc held high see no arbitration gap.
- Watchdog: stb held without ack from cycle K -> err_o high in cycle K+TIMEOUT-1.

## Test plan
- Reset then m0 single read of adr 0x0000_0010 (slave returns 0x1234_5678 with ack on same cycle) -> gnt_o=01 one cycle after request, m0_dat_o=0x1234_5678 with m0_ack_o, m1_ack_o=0.
- m0 and m1 raise cyc in the same cycle after reset -> m0 granted first. m0 drops cyc -> gnt_o=10 the next cycle. Both request again from IDLE -> m0 is granted, because last_gnt=1.
- m1 holds cyc for 4 bursts (stb toggling) while m0 requests -> m0 sees no ack until m1 releases, then m0 is granted in exactly the next cycle.
- m0 write, sel=4'b0011, dat=0xDEAD_BEEF, adr=0x100 -> s_we_o=1, s_sel_o=0011, s_adr_o=0x100, s_dat_o=0xDEAD_BEEF. m1_dat_o stays 0.
- TIMEOUT=8, slave never acks, m1 strobes from cycle K -> m1_err_o pulses exactly at K+7 with s_stb_o=0 that cycle. The counter restarts and, while stb is held and no ack arrives, m1_err_o pulses again at K+15.
- wb_rst_i asserted for one cycle during an m0 transfer -> IDLE and all outputs 0 after the edge. A pending m1 request is granted in the cycle after reset deasserts.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: shares one slave between CPU data (m0) and instruction fetch (m1).
// Latency: grant one cycle after cyc rises while idle; slave path is combinational once granted.
// Backpressure: a master holding cyc keeps ownership; the other waits; stalled strobes get a watchdog err.
module wb_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_gnt;
    logic [15:0] wd_cnt;
    logic        wd_fire;
    logic        owned;
    wb_req_t     m0_req;
    wb_req_t     m1_req;
    wb_req_t     own_req;

    assign m0_req = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign m1_req = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ownership is held for the whole cyc; handover goes straight to the waiting master.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_gnt ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_gnt <= 1'b1;
        end else if (state_nxt == GNT0) begin
            last_gnt <= 1'b0;
        end else if (state_nxt == GNT1) begin
            last_gnt <= 1'b1;
        end
    end

    always_comb begin
        own_req  = '0;
        gnt_o    = 2'b00;
        owned    = 1'b0;
        wd_fire  = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = 32'h0;
        s_dat_o  = 32'h0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = 32'h0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = 32'h0;

        case (state)
            GNT0: begin
                own_req = m0_req;
                gnt_o   = 2'b01;
                owned   = 1'b1;
            end
            GNT1: begin
                own_req = m1_req;
                gnt_o   = 2'b10;
                owned   = 1'b1;
            end
            default: begin
                own_req = '0;
                gnt_o   = 2'b00;
                owned   = 1'b0;
            end
        endcase

        // The err cycle withdraws the strobe so the slave never sees the abandoned access.
        wd_fire = owned && own_req.stb && !s_ack_i && (wd_cnt == WD_LIMIT);

        s_cyc_o = own_req.cyc;
        s_stb_o = own_req.stb && !wd_fire;
        s_we_o  = own_req.we;
        s_sel_o = own_req.sel;
        s_adr_o = own_req.adr;
        s_dat_o = own_req.dat;

        if (state == GNT0) begin
            m0_ack_o = s_ack_i;
            m0_err_o = wd_fire;
            m0_dat_o = s_dat_i;
        end
        if (state == GNT1) begin
            m1_ack_o = s_ack_i;
            m1_err_o = wd_fire;
            m1_dat_o = s_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt <= 16'h0;
        end else if (!owned || s_ack_i || !s_stb_o) begin
            wd_cnt <= 16'h0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

endmodule
